// File: rtl/regfile_wr_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
// Holds the register-file geometry and the write-source encoding.
// The encoding selects the write-port grant and is handy when probing
// which source won a given cycle.
package regfile_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_LL,
        SRC_DBG
    } wr_src_t;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bundle between the write sources, the scheduler and the register file.
//   master : source/issue side; drives the requests, sees readies, busy and
//            the register-file write outputs
//   slave  : the scheduler
// Signals:
//   wb_*      pipeline writeback request (never stalled)
//   ll_*      long-latency result request with ready
//   dbg_*     debug write request with ready
//   res_*     reservation of a long-latency destination
//   busy      per-register scoreboard
//   rf_*      registered register-file write port
interface regfile_wr_sched_if
    import regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
);
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;

    logic              ll_valid;
    logic              ll_ready;
    logic [AW-1:0]     ll_addr;
    logic [DW-1:0]     ll_data;

    logic              dbg_valid;
    logic              dbg_ready;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    logic              res_valid;
    logic [AW-1:0]     res_addr;
    logic [2**AW-1:0]  busy;

    logic              rf_we;
    logic [AW-1:0]     rf_wa;
    logic [DW-1:0]     rf_wd;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output ll_valid, ll_addr, ll_data,
        output dbg_valid, dbg_addr, dbg_data,
        output res_valid, res_addr,
        input  ll_ready, dbg_ready, busy,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ll_valid, ll_addr, ll_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  res_valid, res_addr,
        output ll_ready, dbg_ready, busy,
        output rf_we, rf_wa, rf_wd
    );

endinterface

// File: rtl/regfile_wr_sched_starve_cnt.sv
// Saturating starvation counter for the debug write source.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count one refused cycle
//   clr        : return to zero (has priority over inc)
//   sat        : counter has reached STARVE_LIM
module rf_starve_cnt #(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int            CW  = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == LIM);

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the general-purpose register file.
// Shares the single write port between pipeline writeback (highest),
// long-latency results and the debug port (lowest, promoted above LL once
// it has been refused STARVE_LIM cycles in a row). Keeps a busy scoreboard
// of registers awaiting long-latency results.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/ready, scoreboard and register-file write signals
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int DW         = RF_DW,
    parameter int AW         = RF_AW,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wr_sched_if.slave bus
);

    localparam int NREG = 2**AW;

    wr_src_t         grant;
    logic            starve_sat;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    logic            rf_we_q;
    logic [AW-1:0]   rf_wa_q;
    logic [DW-1:0]   rf_wd_q;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;

    // Readies are gated by reset so nothing handshakes while held in reset.
    always_comb begin
        grant = SRC_NONE;
        if (!rst_n) begin
            grant = SRC_NONE;
        end else if (bus.wb_valid) begin
            grant = SRC_WB;
        end else if (bus.dbg_valid && starve_sat) begin
            grant = SRC_DBG;
        end else if (bus.ll_valid) begin
            grant = SRC_LL;
        end else if (bus.dbg_valid) begin
            grant = SRC_DBG;
        end
    end

    assign bus.ll_ready  = (grant == SRC_LL);
    assign bus.dbg_ready = (grant == SRC_DBG);

    always_comb begin
        win_addr = '0;
        win_data = '0;
        case (grant)
            SRC_WB: begin
                win_addr = bus.wb_addr;
                win_data = bus.wb_data;
            end
            SRC_LL: begin
                win_addr = bus.ll_addr;
                win_data = bus.ll_data;
            end
            SRC_DBG: begin
                win_addr = bus.dbg_addr;
                win_data = bus.dbg_data;
            end
            default: begin
                win_addr = '0;
                win_data = '0;
            end
        endcase
    end

    rf_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.dbg_valid && !bus.dbg_ready),
        .clr   (!bus.dbg_valid || bus.dbg_ready),
        .sat   (starve_sat)
    );

    // r0 is hardwired to zero: the handshake completes but no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else if (grant != SRC_NONE) begin
            rf_we_q <= (win_addr != '0);
            rf_wa_q <= win_addr;
            rf_wd_q <= win_data;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    // Set is applied after clear so a fresh reservation survives an LL
    // result to the same register in the same cycle.
    always_comb begin
        busy_next = busy_q;
        if (grant == SRC_LL) begin
            busy_next[bus.ll_addr] = 1'b0;
        end
        if (bus.res_valid) begin
            busy_next[bus.res_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.rf_we = rf_we_q;
    assign bus.rf_wa = rf_wa_q;
    assign bus.rf_wd = rf_wd_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: directed scenarios followed by randomized
// traffic, all checked every cycle against a behavioural model.
module tb_regfile_wr_sched;
    import regfile_pkg::*;

    localparam int LIM = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_wr_sched_if #(.DW(32), .AW(5)) bus ();

    regfile_wr_sched #(
        .DW         (32),
        .AW         (5),
        .STARVE_LIM (LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int          starve_m;
    logic [31:0] busy_m;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    // DUT values sampled at the last checked negedge
    logic        s_ll_rdy;
    logic        s_dbg_rdy;
    logic [31:0] s_busy;
    int          last_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        starve_m = 0;
        busy_m   = '0;
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    // 0 none, 1 WB, 2 LL, 3 DBG
    function automatic int model_pick();
        if (bus.wb_valid)                        return 1;
        if (bus.dbg_valid && (starve_m >= LIM))  return 3;
        if (bus.ll_valid)                        return 2;
        if (bus.dbg_valid)                       return 3;
        return 0;
    endfunction

    task automatic mwrite(input logic [4:0] a, input logic [31:0] d);
        m_we = (a != 5'd0);
        m_wa = a;
        m_wd = d;
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1.
    task automatic cycle();
        int g;
        @(negedge clk);
        g = rst_n ? model_pick() : 0;
        s_ll_rdy  = bus.ll_ready;
        s_dbg_rdy = bus.dbg_ready;
        s_busy    = bus.busy;
        chk("ll_ready",  32'(s_ll_rdy),  32'(g == 2));
        chk("dbg_ready", 32'(s_dbg_rdy), 32'(g == 3));
        chk("rf_we",     32'(bus.rf_we), 32'(m_we));
        chk("rf_wa",     32'(bus.rf_wa), 32'(m_wa));
        chk("rf_wd",     bus.rf_wd,      m_wd);
        chk("busy",      s_busy,         busy_m);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            case (g)
                1:       mwrite(bus.wb_addr,  bus.wb_data);
                2:       mwrite(bus.ll_addr,  bus.ll_data);
                3:       mwrite(bus.dbg_addr, bus.dbg_data);
                default: m_we = 1'b0;
            endcase
            if (bus.dbg_valid && (g != 3))
                starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
            else
                starve_m = 0;
            if (g == 2)
                busy_m[bus.ll_addr] = 1'b0;
            if (bus.res_valid && (bus.res_addr != 5'd0))
                busy_m[bus.res_addr] = 1'b1;
        end
        last_g = g;
        #1;
    endtask

    task automatic all_idle();
        bus.wb_valid  = 1'b0;
        bus.ll_valid  = 1'b0;
        bus.dbg_valid = 1'b0;
        bus.res_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        last_g        = 0;
        bus.wb_valid  = 1'b1; bus.wb_addr  = 5'd1;  bus.wb_data  = 32'h11;
        bus.ll_valid  = 1'b1; bus.ll_addr  = 5'd2;  bus.ll_data  = 32'h22;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd4;  bus.dbg_data = 32'h44;
        bus.res_valid = 1'b1; bus.res_addr = 5'd6;

        // reset held with every request asserted
        #3;
        chk("rst_ll_ready",  32'(bus.ll_ready),  32'd0);
        chk("rst_dbg_ready", 32'(bus.dbg_ready), 32'd0);
        chk("rst_rf_we",     32'(bus.rf_we),     32'd0);
        chk("rst_busy",      bus.busy,           32'd0);
        cycle();
        cycle();
        all_idle();
        rst_n = 1'b1;

        // first write after reset
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
        cycle();
        bus.wb_valid = 1'b0;
        chk("first_we", 32'(bus.rf_we), 32'd1);
        chk("first_wa", 32'(bus.rf_wa), 32'd3);
        chk("first_wd", bus.rf_wd,       32'hDEADBEEF);
        cycle();

        // priority: WB, then LL, then DBG
        bus.wb_valid  = 1'b1; bus.wb_addr  = 5'd1; bus.wb_data  = 32'hA1;
        bus.ll_valid  = 1'b1; bus.ll_addr  = 5'd2; bus.ll_data  = 32'hA2;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd4; bus.dbg_data = 32'hA4;
        cycle();
        chk("prio1_ll_rdy",  32'(s_ll_rdy),  32'd0);
        chk("prio1_dbg_rdy", 32'(s_dbg_rdy), 32'd0);
        chk("prio1_wa",      32'(bus.rf_wa), 32'd1);
        bus.wb_valid = 1'b0;
        cycle();
        chk("prio2_ll_rdy",  32'(s_ll_rdy),  32'd1);
        chk("prio2_dbg_rdy", 32'(s_dbg_rdy), 32'd0);
        chk("prio2_wa",      32'(bus.rf_wa), 32'd2);
        bus.ll_valid = 1'b0;
        cycle();
        chk("prio3_dbg_rdy", 32'(s_dbg_rdy), 32'd1);
        chk("prio3_wa",      32'(bus.rf_wa), 32'd4);
        chk("prio3_wd",      bus.rf_wd,      32'hA4);
        bus.dbg_valid = 1'b0;
        cycle();

        // starvation: DBG wins in the 9th refused cycle, then restarts from 0
        bus.ll_valid  = 1'b1; bus.ll_addr  = 5'd10; bus.ll_data  = 32'h0BAD0BAD;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd5;  bus.dbg_data = 32'h1234;
        for (int i = 1; i <= 18; i++) begin
            cycle();
            chk($sformatf("starve_dbg_rdy_%0d", i), 32'(s_dbg_rdy), 32'((i == 9) || (i == 18)));
        end
        all_idle();
        cycle();

        // scoreboard: RES 7, LL 7 three cycles later
        bus.res_valid = 1'b1; bus.res_addr = 5'd7;
        cycle();
        bus.res_valid = 1'b0;
        cycle();
        chk("sb7_a", 32'(s_busy[7]), 32'd1);
        cycle();
        chk("sb7_b", 32'(s_busy[7]), 32'd1);
        bus.ll_valid = 1'b1; bus.ll_addr = 5'd7; bus.ll_data = 32'h77;
        cycle();
        chk("sb7_c", 32'(s_busy[7]), 32'd1);
        bus.ll_valid = 1'b0;
        cycle();
        chk("sb7_d", 32'(s_busy[7]), 32'd0);

        // same-cycle RES and LL on 9: set wins
        bus.res_valid = 1'b1; bus.res_addr = 5'd9;
        bus.ll_valid  = 1'b1; bus.ll_addr  = 5'd9; bus.ll_data = 32'h99;
        cycle();
        all_idle();
        cycle();
        chk("sb9", 32'(s_busy[9]), 32'd1);

        // address 0: handshake completes, no write, no reservation
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'h55;
        cycle();
        chk("a0_dbg_rdy", 32'(s_dbg_rdy), 32'd1);
        bus.dbg_valid = 1'b0;
        chk("a0_rf_we", 32'(bus.rf_we), 32'd0);
        bus.res_valid = 1'b1; bus.res_addr = 5'd0;
        cycle();
        bus.res_valid = 1'b0;
        cycle();
        chk("a0_busy", s_busy, 32'h0000_0200);

        // async reset in the middle of a stalled DBG request
        bus.ll_valid  = 1'b1; bus.ll_addr  = 5'd12; bus.ll_data  = 32'hC0FFEE;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd13; bus.dbg_data = 32'hD00D;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we",      32'(bus.rf_we),     32'd0);
        chk("mid_rst_wa",      32'(bus.rf_wa),     32'd0);
        chk("mid_rst_wd",      bus.rf_wd,          32'd0);
        chk("mid_rst_busy",    bus.busy,           32'd0);
        chk("mid_rst_ll_rdy",  32'(bus.ll_ready),  32'd0);
        chk("mid_rst_dbg_rdy", 32'(bus.dbg_ready), 32'd0);
        model_reset();
        cycle();
        cycle();
        all_idle();
        rst_n = 1'b1;
        cycle();

        // randomized traffic; LL/DBG hold their request until accepted
        for (int i = 0; i < 600; i++) begin
            bus.wb_valid = ($urandom_range(3) == 0);
            bus.wb_addr  = 5'($urandom);
            bus.wb_data  = $urandom;
            if (!bus.ll_valid || (last_g == 2)) begin
                bus.ll_valid = ($urandom_range(1) == 0);
                bus.ll_addr  = 5'($urandom);
                bus.ll_data  = $urandom;
            end
            if (!bus.dbg_valid || (last_g == 3)) begin
                bus.dbg_valid = ($urandom_range(2) == 0);
                bus.dbg_addr  = 5'($urandom);
                bus.dbg_data  = $urandom;
            end
            bus.res_valid = ($urandom_range(3) == 0);
            bus.res_addr  = 5'($urandom);
            cycle();
        end
        all_idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
